// File: rtl/i_fetch_queue.sv
// Instruction fetch queue: in-order {pc, instr} buffer between icache and decode.
// Latency: push visible at head 1 cycle later; no in->out bypass.
// Backpressure: in_ready = not full (independent of out_ready); redirect/reset drop all entries.
module i_fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     in_valid,
  input  logic [ADDR_WIDTH-1:0]    in_pc,
  input  logic [DATA_WIDTH-1:0]    in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [ADDR_WIDTH-1:0]    out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Pointer arithmetic relies on natural wrap, so DEPTH must be a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("i_fetch_queue: DEPTH must be a power of two and >= 2");
  end

  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  push;
  logic                  pop;

  // Handshakes: full refuses pushes even if decode pops this cycle, so in_ready
  // never depends on out_ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_pc    = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];
  assign o_count   = count;

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage: zeroed on reset so the head reads 0 afterwards; otherwise written
  // only on push (pop and flush leave stale contents in place).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push && !i_flush) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  // Occupancy sanity: never above DEPTH, never popped while empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= CW'(DEPTH));
      assert (!(pop && count == '0));
    end
  end

endmodule

// File: tb/tb_i_fetch_queue.sv
// Bench for i_fetch_queue: directed scenarios plus random traffic against a queue model.
// Stimulus drives inputs just after posedge; the monitor samples at negedge.
// Expected status and popped entries flow through scoreboard queues.
module tb_i_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 26;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_pc = '0;
  logic [DW-1:0] in_instr = '0;
  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_instr;
  logic          out_ready = 1'b0;
  logic [2:0]    o_count;

  i_fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  typedef struct packed {
    logic          en;
    logic [2:0]    cnt;
    logic          rdy;
    logic          vld;
    logic          chk_head;
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } stat_t;

  ent_t  mq[$];    // reference contents, head at index 0
  ent_t  exq[$];   // entries expected to leave the DUT, in order
  stat_t stq[$];   // expected visible status for each driven cycle
  bit    known      = 0;
  bit    zero_state = 0;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model advances by the same rules.
  task automatic step(input bit r, input bit f, input bit v, input logic [AW-1:0] pc,
                      input bit ordy);
    stat_t s;
    ent_t  e;
    bit    do_pop, do_push;
    @(posedge clk); #1;
    e.pc    = pc;
    e.instr = $urandom;
    rst = r; i_flush = f; in_valid = v; in_pc = e.pc; in_instr = e.instr; out_ready = ordy;
    s.en       = known;
    s.cnt      = 3'(mq.size());
    s.rdy      = (mq.size() != DEPTH);
    s.vld      = (mq.size() != 0);
    s.chk_head = known && (mq.size() != 0 || zero_state);
    s.pc       = (mq.size() != 0) ? mq[0].pc : '0;
    s.instr    = (mq.size() != 0) ? mq[0].instr : '0;
    stq.push_back(s);
    if (r) begin
      mq.delete();
      known = 1;
      zero_state = 1;
    end else if (f) begin
      mq.delete();
    end else if (known) begin
      do_pop  = (mq.size() != 0) && ordy;
      do_push = v && (mq.size() != DEPTH);
      if (do_pop) begin
        exq.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (do_push) begin
        mq.push_back(e);
        zero_state = 0;
      end
    end
  endtask

  // Monitor: status every cycle, data on every DUT pop.
  initial begin
    stat_t s;
    ent_t  e;
    forever begin
      @(negedge clk);
      if (stq.size() != 0) begin
        s = stq.pop_front();
        if (s.en) begin
          chk("o_count",   64'(o_count),   64'(s.cnt));
          chk("in_ready",  64'(in_ready),  64'(s.rdy));
          chk("out_valid", 64'(out_valid), 64'(s.vld));
          if (s.chk_head) begin
            chk("head_pc",    64'(out_pc),    64'(s.pc));
            chk("head_instr", 64'(out_instr), 64'(s.instr));
          end
        end
      end
      if (out_valid === 1'b1 && out_ready && !i_flush && !rst) begin
        if (exq.size() == 0) begin
          chk("unexpected_pop", 64'(out_pc), 64'hDEAD);
        end else begin
          e = exq.pop_front();
          chk("pop_pc",    64'(out_pc),    64'(e.pc));
          chk("pop_instr", 64'(out_instr), 64'(e.instr));
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] pc;
    // Reset for two cycles.
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    // Fill to full, then an extra push that must be ignored.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 26'h100 + 26'(4 * i), 0);
    step(0, 0, 1, 26'h110, 0);
    step(0, 0, 1, 26'h110, 1);   // full + pop: push still refused
    // Drain remaining entries, then observe empty.
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);        // pop on empty: no change
    // Streaming at count 2.
    step(0, 0, 1, 26'h300, 0);
    step(0, 0, 1, 26'h304, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 26'h308 + 26'(4 * i), 1);
    step(0, 0, 0, '0, 0);
    // Flush at count 3 with concurrent push and pop.
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 26'h400 + 26'(4 * i), 0);
    step(0, 1, 1, 26'h200, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 1, 26'h500, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 0);
    // Reset mid-stream with push and pop asserted.
    step(0, 0, 1, 26'h600, 0);
    step(0, 0, 1, 26'h604, 0);
    step(1, 0, 1, 26'h608, 1);
    step(0, 0, 1, 26'h700, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 0);
    // Random traffic with occasional flush and reset.
    pc = 26'h1000;
    for (int i = 0; i < 400; i++) begin
      bit r, f, v, o;
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 5);
      v = ($urandom_range(0, 99) < 60);
      o = ($urandom_range(0, 99) < 50);
      step(r, f, v, pc, o);
      pc = pc + 26'd4;
    end
    // Final drain.
    for (int i = 0; i < 6; i++) step(0, 0, 0, '0, 1);
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    @(negedge clk);
    chk("leftover_expected_pops", 64'(exq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
